i2c_slave_regs: RTL and testbench



---
 rtl/i2c_slave_regs.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target with a small byte-wide register file. The first byte of a write sets the
// register pointer, later bytes are stored at the pointer; reads stream registers out from it.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int          NUM_REGS   = 4,
    parameter int          PTR_W      = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic                  busy,
    output logic                  addr_hit,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX_BYTE  = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX_BYTE  = 3'd5,
        S_TX_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [7:0]                 shift_q, shift_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic                       first_q, first_d;
    logic                       phase_q, phase_d;
    logic                       rw_q, rw_d;
    logic                       sda_oe_q, sda_oe_d;
    logic                       busy_q, busy_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]           wr_index_q, wr_index_d;
    logic                       addr_hit_q, addr_hit_d;
    logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       addr_match;
    logic [7:0] rx_byte;
    logic [7:0] cur_reg;
    logic       tx_bit;

    // Bus idles high, so the synchronisers reset to 1 to avoid phantom edges after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise   = scl_s2_q & ~scl_h_q;
    assign scl_fall   = ~scl_s2_q & scl_h_q;
    assign start_det  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    assign addr_match = (shift_q[6:0] == SLAVE_ADDR);
    assign rx_byte    = {shift_q[6:0], sda_s2_q};
    assign cur_reg    = regs_q[ptr_q];
    assign tx_bit     = shift_q[3'd7 - bit_cnt_q[2:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q == 4'd7) begin
                        state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall && phase_q) begin
                        state_d = rw_q ? S_TX_BYTE : S_RX_BYTE;
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise && bit_cnt_q == 4'd7) begin
                        state_d = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall && phase_q) begin
                        state_d = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = S_TX_ACK;
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = S_IGNORE;
                    end else if (scl_fall && phase_q) begin
                        state_d = S_TX_BYTE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // phase_q marks the second half of a two-fall step: ACK driven, or master ACK seen.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        first_d     = first_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        addr_hit_d  = 1'b0;
        regs_d      = regs_q;
        if (start_det) begin
            bit_cnt_d = 4'd0;
            shift_d   = 8'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            rw_d      = sda_s2_q;
                            phase_d   = 1'b0;
                            if (addr_match) begin
                                busy_d = 1'b1;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d   = 1'b1;
                            addr_hit_d = 1'b1;
                            phase_d    = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            first_d = ~rw_q;
                            if (rw_q) begin
                                shift_d   = cur_reg;
                                ptr_d     = ptr_q + PTR_W'(1);
                                sda_oe_d  = ~cur_reg[7];
                                bit_cnt_d = 4'd1;
                            end else begin
                                sda_oe_d  = 1'b0;
                                bit_cnt_d = 4'd0;
                            end
                        end
                    end
                end
                S_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            if (first_q) begin
                                ptr_d   = rx_byte[PTR_W-1:0];
                                first_d = 1'b0;
                            end else begin
                                regs_d[ptr_q] = rx_byte;
                                wr_strobe_d   = 1'b1;
                                wr_index_d    = ptr_q;
                                ptr_d         = ptr_q + PTR_W'(1);
                            end
                        end
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = ~phase_q;
                        phase_d  = ~phase_q;
                    end
                end
                S_TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                        end else begin
                            sda_oe_d  = ~tx_bit;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise) begin
                        phase_d  = ~sda_s2_q;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        shift_d   = cur_reg;
                        ptr_d     = ptr_q + PTR_W'(1);
                        sda_oe_d  = ~cur_reg[7];
                        bit_cnt_d = 4'd1;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= '0;
            first_q     <= 1'b0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            addr_hit_q  <= 1'b0;
            regs_q      <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            first_q     <= first_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            addr_hit_q  <= addr_hit_d;
            regs_q      <= regs_d;
        end
    end

    // Open-drain: only ever pull low; the asynchronous reset of sda_oe_q frees the bus at once.
    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;
    assign addr_hit  = addr_hit_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged bus master, a table of write vectors,
// and hand-written sequences for reads, mismatches, aborts and reset during an ACK.
module tb_i2c_slave_regs;
  localparam int Q = 5;
  localparam int H = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_oe = 1'b0;
  wire         sda;
  logic [31:0] regs_out;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;
  logic        addr_hit;
  logic [2:0]  state_dbg;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .NUM_REGS(4), .PTR_W(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .scl      (scl),
    .sda      (sda),
    .regs_out (regs_out),
    .wr_strobe(wr_strobe),
    .wr_index (wr_index),
    .busy     (busy),
    .addr_hit (addr_hit),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  int          hit_cnt = 0;
  int          exp_hits = 0;
  int          slave_low_cnt = 0;
  int          dbl_pulse = 0;
  logic        prev_ws = 1'b0;
  logic        prev_ah = 1'b0;
  logic [9:0]  exp_q[$];
  logic [9:0]  exp_e;
  int          exp_k;
  logic [31:0] exp_regs = 32'd0;

  typedef struct {
    logic [7:0] ptr_byte;
    logic [7:0] data;
    logic [1:0] exp_idx;
  } wr_vec_t;
  wr_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every wr_strobe must match the next expected {index, data}
  always @(negedge clock) begin
    if (reset_n) begin
      if (addr_hit) hit_cnt++;
      if ((wr_strobe && prev_ws) || (addr_hit && prev_ah)) dbl_pulse++;
      prev_ws = wr_strobe;
      prev_ah = addr_hit;
      if (wr_strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected wr_strobe: index %0d, no write expected", wr_index);
        end else begin
          exp_e = exp_q.pop_front();
          exp_k = int'(exp_e[9:8]);
          check("wr_index", 32'(wr_index), 32'(exp_e[9:8]));
          check("written byte", 32'(regs_out[8*exp_k +: 8]), 32'(exp_e[7:0]));
        end
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && sda === 1'b0 && !m_oe) slave_low_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_cond();
    wclk(Q); m_oe = 1'b0;
    wclk(Q); scl = 1'b1;
    wclk(Q); m_oe = 1'b1;
    wclk(Q); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wclk(Q); m_oe = 1'b1;
    wclk(Q); scl = 1'b1;
    wclk(Q); m_oe = 1'b0;
    wclk(H);
  endtask

  task automatic send_bit(input logic b);
    wclk(Q); m_oe = ~b;
    wclk(Q); scl = 1'b1;
    wclk(H); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wclk(Q); m_oe = 1'b0;
    wclk(Q); scl = 1'b1;
    wclk(Q); b = sda;
    wclk(Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input logic [7:0] data, input logic [1:0] idx);
    logic a;
    start_cond();
    send_byte(8'h84, a); check("addr ack", 32'(a), 32'd1); exp_hits++;
    send_byte(ptr, a);   check("ptr ack", 32'(a), 32'd1);
    exp_q.push_back({idx, data});
    exp_regs[8*int'(idx) +: 8] = data;
    send_byte(data, a);  check("data ack", 32'(a), 32'd1);
    stop_cond();
    check("regs_out", regs_out, exp_regs);
    check("busy after stop", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         lo0, h0;

    vecs[0] = '{ptr_byte: 8'hFE, data: 8'h99, exp_idx: 2'd2};
    vecs[1] = '{ptr_byte: 8'h07, data: 8'h5A, exp_idx: 2'd3};
    vecs[2] = '{ptr_byte: 8'h04, data: 8'hC3, exp_idx: 2'd0};
    vecs[3] = '{ptr_byte: 8'h11, data: 8'h6E, exp_idx: 2'd1};

    // reset state
    wclk(4);
    check("reset regs_out", regs_out, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset wr_index", 32'(wr_index), 32'd0);
    check("reset addr_hit", 32'(addr_hit), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    check("reset sda", 32'(sda), 32'd1);
    reset_n = 1'b1;
    wclk(4);

    // write with pointer: ptr 1, data A5, 3C
    start_cond();
    send_byte(8'h84, a); check("w1 addr ack", 32'(a), 32'd1); exp_hits++;
    check("w1 busy", 32'(busy), 32'd1);
    send_byte(8'h01, a); check("w1 ptr ack", 32'(a), 32'd1);
    exp_q.push_back({2'd1, 8'hA5});
    send_byte(8'hA5, a); check("w1 data0 ack", 32'(a), 32'd1);
    exp_q.push_back({2'd2, 8'h3C});
    send_byte(8'h3C, a); check("w1 data1 ack", 32'(a), 32'd1);
    stop_cond();
    exp_regs = 32'h003C_A500;
    check("w1 regs_out", regs_out, exp_regs);
    check("w1 busy after stop", 32'(busy), 32'd0);
    check("w1 writes consumed", 32'(exp_q.size()), 32'd0);

    // table of single-byte writes, including pointer bytes with high bits set
    for (int v = 0; v < 4; v++) begin
      write_txn(vecs[v].ptr_byte, vecs[v].data, vecs[v].exp_idx);
    end
    check("table writes consumed", 32'(exp_q.size()), 32'd0);

    // read with wrap: ptr 3, repeated START, read reg3 (ACK) then reg0 (NACK)
    start_cond();
    send_byte(8'h84, a); check("rd addr w ack", 32'(a), 32'd1); exp_hits++;
    send_byte(8'h03, a); check("rd ptr ack", 32'(a), 32'd1);
    start_cond();
    send_byte(8'h85, a); check("rd addr r ack", 32'(a), 32'd1); exp_hits++;
    recv_byte(d, 1'b1); check("rd byte0 reg3", 32'(d), 32'h5A);
    recv_byte(d, 1'b0); check("rd byte1 reg0", 32'(d), 32'hC3);
    wclk(3);
    check("rd sda released after nack", 32'(sda), 32'd1);
    check("rd state ignore", 32'(state_dbg), 32'd7);
    stop_cond();
    check("rd busy after stop", 32'(busy), 32'd0);
    start_cond();
    send_byte(8'h85, a); check("rd2 addr ack", 32'(a), 32'd1); exp_hits++;
    recv_byte(d, 1'b0); check("rd2 ptr was 1", 32'(d), 32'h6E);
    stop_cond();

    // address mismatch
    lo0 = slave_low_cnt;
    h0 = hit_cnt;
    start_cond();
    send_byte(8'h90, a); check("mm no ack", 32'(a), 32'd0);
    send_byte(8'h55, a);
    stop_cond();
    check("mm sda never driven", 32'(slave_low_cnt - lo0), 32'd0);
    check("mm no addr_hit", 32'(hit_cnt - h0), 32'd0);
    check("mm regs unchanged", regs_out, exp_regs);
    check("mm busy", 32'(busy), 32'd0);

    // abort: STOP after 5 data bits
    start_cond();
    send_byte(8'h84, a); check("ab addr ack", 32'(a), 32'd1); exp_hits++;
    send_byte(8'h02, a); check("ab ptr ack", 32'(a), 32'd1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    stop_cond();
    check("ab state idle", 32'(state_dbg), 32'd0);
    check("ab busy", 32'(busy), 32'd0);
    check("ab regs unchanged", regs_out, exp_regs);
    write_txn(8'h02, 8'h77, 2'd2);

    // reset while the slave holds the data ACK
    start_cond();
    send_byte(8'h84, a); check("rs addr ack", 32'(a), 32'd1); exp_hits++;
    send_byte(8'h00, a); check("rs ptr ack", 32'(a), 32'd1);
    exp_q.push_back({2'd0, 8'h11});
    for (int i = 7; i >= 0; i--) send_bit(i == 4 || i == 0);
    wclk(Q); m_oe = 1'b0;
    wclk(2);
    check("rs slave holds ack", 32'(sda), 32'd0);
    check("rs state rx_ack", 32'(state_dbg), 32'd4);
    reset_n = 1'b0;
    #1;
    check("rs sda released", 32'(sda), 32'd1);
    check("rs regs cleared", regs_out, 32'd0);
    check("rs busy", 32'(busy), 32'd0);
    check("rs state", 32'(state_dbg), 32'd0);
    exp_regs = 32'd0;
    wclk(3); scl = 1'b1;
    wclk(3); reset_n = 1'b1;
    wclk(4);
    write_txn(8'h00, 8'h3E, 2'd0);

    // final report
    check("addr_hit count", 32'(hit_cnt), 32'(exp_hits));
    check("single-cycle pulses", 32'(dbl_pulse), 32'd0);
    check("all writes seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
